// File: rtl/grid_glyph_sequencer.sv
// grid_glyph_sequencer
//   Scan-time controller for the 9x9 Sudoku grid (40x40 px cells). Tracks
//   the beam's cell and in-cell position with counters, fetches the cell's
//   digit from board RAM, drives font_provider, and merges the returned
//   colour code with the blinking cursor border and the background. de and
//   the syncs travel alongside so that timing and colour leave aligned.
//
// Ports
//   clk, rst_n               pixel clock, asynchronous active-low reset
//   pixel_x, pixel_y         beam position from the timing generator
//   de_in, hsync_in, vsync_in  active video and active-low syncs
//   cursor_row, cursor_col   cursor cell, captured once per frame
//   board_addr, board_data   board RAM read port (row*9+col; {user, digit})
//   font_digit, font_pos     request to font_provider
//   font_color               font_provider colour code
//   color_out                final colour code
//   de_out, hsync_out, vsync_out  timing delayed to match color_out

package screen;
  typedef struct packed {
    logic [5:0] line;
    logic [5:0] pixel;
  } position;
endpackage

module grid_glyph_sequencer #(
  parameter logic [9:0] GRID_X       = 10'd140,
  parameter logic [9:0] GRID_Y       = 10'd60,
  parameter int         BOARD_LAT    = 1,
  parameter int         FONT_LAT     = 2,
  parameter int         BLINK_FRAMES = 30,
  parameter logic [2:0] BG_CODE      = 3'b000,
  parameter logic [2:0] CURSOR_CODE  = 3'b100,
  parameter logic [2:0] USER_CODE    = 3'b010
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [9:0]     pixel_x,
  input  logic [9:0]     pixel_y,
  input  logic           de_in,
  input  logic           hsync_in,
  input  logic           vsync_in,
  input  logic [3:0]     cursor_row,
  input  logic [3:0]     cursor_col,
  output logic [6:0]     board_addr,
  input  logic [4:0]     board_data,
  output logic [3:0]     font_digit,
  output screen::position font_pos,
  input  logic [2:0]     font_color,
  output logic [2:0]     color_out,
  output logic           de_out,
  output logic           hsync_out,
  output logic           vsync_out
);

  localparam int S_DATA = 1 + BOARD_LAT;
  localparam int S_FONT = S_DATA + FONT_LAT;
  localparam int FCW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef struct packed {
    logic       in_grid;
    logic       hit;
    logic       user;
    logic       de;
    logic       hs;
    logic       vs;
    logic [5:0] px;
    logic [5:0] ln;
  } side_t;

  localparam side_t SIDE_IDLE = '{in_grid: 1'b0, hit: 1'b0, user: 1'b0,
                                  de: 1'b0, hs: 1'b1, vs: 1'b1,
                                  px: 6'd0, ln: 6'd0};

  logic [5:0]      px_q, px_d, ln_q, ln_d;
  logic [3:0]      col_q, col_d, row_q, row_d;
  logic            in_grid_d, hit_d;
  logic            vs_prev_q, vs_prev_d, vs_fall;
  logic [3:0]      cur_row_q, cur_row_d, cur_col_q, cur_col_d;
  logic [FCW-1:0]  frame_q, frame_d;
  logic            blink_q, blink_d;
  side_t           pipe_q [0:S_FONT];
  side_t           pipe_d [0:S_FONT];
  logic [6:0]      board_addr_q, board_addr_d;
  logic [3:0]      font_digit_q, font_digit_d;
  screen::position font_pos_q, font_pos_d;
  logic [2:0]      font_color_q, font_color_d;
  logic [2:0]      color_out_q, color_out_d;
  logic            de_out_q, de_out_d, hsync_out_q, hsync_out_d;
  logic            vsync_out_q, vsync_out_d;

  function automatic logic on_border(input logic [5:0] v);
    return (v < 6'd2) || (v > 6'd37);
  endfunction

  // Stage 0: beam position counters, in-grid and cursor-hit decode.
  // Horizontal counters restart at every GRID_X crossing; vertical counters
  // only advance there, so each line moves them exactly once.
  always_comb begin
    px_d  = px_q;
    col_d = col_q;
    ln_d  = ln_q;
    row_d = row_q;
    if (pixel_x == GRID_X) begin
      px_d  = 6'd0;
      col_d = 4'd0;
      if (pixel_y == GRID_Y) begin
        ln_d  = 6'd0;
        row_d = 4'd0;
      end else if (row_q < 4'd9) begin
        if (ln_q == 6'd39) begin
          ln_d  = 6'd0;
          row_d = row_q + 4'd1;
        end else begin
          ln_d = ln_q + 6'd1;
        end
      end
    end else if (col_q < 4'd9) begin
      if (px_q == 6'd39) begin
        px_d  = 6'd0;
        col_d = col_q + 4'd1;
      end else begin
        px_d = px_q + 6'd1;
      end
    end
    in_grid_d = de_in && (col_d < 4'd9) && (row_d < 4'd9) && (pixel_x >= GRID_X);
    // Rows/cols in the grid never exceed 8, so an out-of-range cursor never matches.
    hit_d = in_grid_d && blink_q && (row_d == cur_row_q) && (col_d == cur_col_q) &&
            (on_border(px_d) || on_border(ln_d));
  end

  // Frame-rate state: cursor latch and blink advance on vsync falling edges.
  always_comb begin
    vs_prev_d = vsync_in;
    vs_fall   = vs_prev_q && !vsync_in;
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    frame_d   = frame_q;
    blink_d   = blink_q;
    if (vs_fall) begin
      cur_row_d = cursor_row;
      cur_col_d = cursor_col;
      if (frame_q == FCW'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        blink_d = !blink_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  // Sideband shift pipeline; the user flag joins when board data arrives.
  always_comb begin
    pipe_d[0] = '{in_grid: in_grid_d, hit: hit_d, user: 1'b0, de: de_in,
                  hs: hsync_in, vs: vsync_in, px: px_d, ln: ln_d};
    for (int i = 1; i <= S_FONT; i++) begin
      pipe_d[i] = pipe_q[i-1];
      if (i == S_DATA) pipe_d[i].user = pipe_q[i-1].in_grid & board_data[4];
    end
  end

  // Stage 1: board address from the registered cell indices.
  // Stage 1+BOARD_LAT: board data in, font request out.
  // Stage 1+BOARD_LAT+FONT_LAT: font colour captured.
  always_comb begin
    board_addr_d = pipe_q[0].in_grid ? (7'(row_q) * 7'd9 + 7'(col_q)) : board_addr_q;
    font_digit_d = pipe_q[S_DATA-1].in_grid ? board_data[3:0] : 4'd0;
    font_pos_d   = '0;
    if (pipe_q[S_DATA-1].in_grid) begin
      font_pos_d.line  = pipe_q[S_DATA-1].ln;
      font_pos_d.pixel = pipe_q[S_DATA-1].px;
    end
    font_color_d = font_color;
  end

  // Output stage: colour merge by priority, aligned timing.
  always_comb begin
    if (!pipe_q[S_FONT].de || !pipe_q[S_FONT].in_grid) color_out_d = BG_CODE;
    else if (pipe_q[S_FONT].hit)                         color_out_d = CURSOR_CODE;
    else if (pipe_q[S_FONT].user && font_color_q == 3'b001) color_out_d = USER_CODE;
    else                                                 color_out_d = font_color_q;
    de_out_d    = pipe_q[S_FONT].de;
    hsync_out_d = pipe_q[S_FONT].hs;
    vsync_out_d = pipe_q[S_FONT].vs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q         <= 6'd0;
      ln_q         <= 6'd0;
      col_q        <= 4'd9;
      row_q        <= 4'd9;
      vs_prev_q    <= 1'b1;
      cur_row_q    <= 4'd0;
      cur_col_q    <= 4'd0;
      frame_q      <= '0;
      blink_q      <= 1'b1;
      for (int i = 0; i <= S_FONT; i++) pipe_q[i] <= SIDE_IDLE;
      board_addr_q <= 7'd0;
      font_digit_q <= 4'd0;
      font_pos_q   <= '0;
      font_color_q <= 3'd0;
      color_out_q  <= BG_CODE;
      de_out_q     <= 1'b0;
      hsync_out_q  <= 1'b1;
      vsync_out_q  <= 1'b1;
    end else begin
      px_q         <= px_d;
      ln_q         <= ln_d;
      col_q        <= col_d;
      row_q        <= row_d;
      vs_prev_q    <= vs_prev_d;
      cur_row_q    <= cur_row_d;
      cur_col_q    <= cur_col_d;
      frame_q      <= frame_d;
      blink_q      <= blink_d;
      for (int i = 0; i <= S_FONT; i++) pipe_q[i] <= pipe_d[i];
      board_addr_q <= board_addr_d;
      font_digit_q <= font_digit_d;
      font_pos_q   <= font_pos_d;
      font_color_q <= font_color_d;
      color_out_q  <= color_out_d;
      de_out_q     <= de_out_d;
      hsync_out_q  <= hsync_out_d;
      vsync_out_q  <= vsync_out_d;
    end
  end

  assign board_addr = board_addr_q;
  assign font_digit = font_digit_q;
  assign font_pos   = font_pos_q;
  assign color_out  = color_out_q;
  assign de_out     = de_out_q;
  assign hsync_out  = hsync_out_q;
  assign vsync_out  = vsync_out_q;

endmodule

// File: tb/tb_grid_glyph_sequencer.sv
// Bench for grid_glyph_sequencer: drives compressed raster frames with a
// randomized board and de pattern, models board RAM and font_provider, and
// compares every output against a coordinate-arithmetic reference model.
module tb_grid_glyph_sequencer;

  localparam int GX = 140;
  localparam int GY = 60;
  localparam int BF = 30;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [9:0]      pixel_x = '0, pixel_y = '0;
  logic            de_in = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic [3:0]      cursor_row = '0, cursor_col = '0;
  logic [6:0]      board_addr;
  logic [4:0]      board_data;
  logic [3:0]      font_digit;
  screen::position font_pos;
  logic [2:0]      font_color;
  logic [2:0]      color_out;
  logic            de_out, hsync_out, vsync_out;

  always #5 clk = ~clk;

  grid_glyph_sequencer dut (
    .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .cursor_row(cursor_row), .cursor_col(cursor_col),
    .board_addr(board_addr), .board_data(board_data),
    .font_digit(font_digit), .font_pos(font_pos), .font_color(font_color),
    .color_out(color_out), .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  // Board RAM: data valid one edge after the registered address.
  logic [4:0] board [0:80];
  assign board_data = (board_addr <= 7'd80) ? board[board_addr] : 5'd0;

  // Font provider: colour is a fixed function of digit and position, two edges later.
  function automatic logic [2:0] font_f(input logic [3:0] d, input logic [5:0] ln, input logic [5:0] px);
    if (d == 4'd0) return 3'd0;
    return 3'(int'(d) + int'(ln) + 2 * int'(px));
  endfunction

  logic [2:0] fc_q = 3'd0;
  always @(posedge clk) fc_q <= font_f(font_digit, font_pos.line, font_pos.pixel);
  assign font_color = fc_q;

  typedef struct {
    logic [2:0]  col;
    logic        de, hs, vs;
    logic [6:0]  addr;
    logic [3:0]  dig;
    logic [11:0] pos;
  } exp_t;

  exp_t ring [0:7];
  int   cyc = 16;
  int   err_cnt = 0, chk_cnt = 0;
  int   nfalls, cur_r, cur_c, last_addr;
  bit   prev_vs;
  bit   sweep_y [0:511];
  int   chg_line = -1, chg_col = 0, rst_line = -1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    exp_t b;
    b.col = 3'b000; b.de = 1'b0; b.hs = 1'b1; b.vs = 1'b1;
    b.addr = 7'd0; b.dig = 4'd0; b.pos = 12'd0;
    for (int i = 0; i < 8; i++) ring[i] = b;
    nfalls = 0; cur_r = 0; cur_c = 0; last_addr = 0; prev_vs = 1'b1;
  endtask

  // Expected result for one driven pixel, from grid geometry alone.
  task automatic model_push(input int x, input int y, input bit de, input bit hs, input bit vs);
    exp_t e;
    int c, r, px, ln, a;
    logic [4:0] d;
    logic [2:0] fc;
    bit blink;
    e.col = 3'b000; e.de = de; e.hs = hs; e.vs = vs; e.dig = 4'd0; e.pos = 12'd0;
    if (de && x >= GX && x < GX + 360 && y >= GY && y < GY + 360) begin
      c = (x - GX) / 40; r = (y - GY) / 40;
      px = (x - GX) % 40; ln = (y - GY) % 40;
      a = r * 9 + c;
      last_addr = a;
      d = board[a];
      fc = font_f(d[3:0], 6'(ln), 6'(px));
      blink = ((nfalls / BF) % 2) == 0;
      if (blink && r == cur_r && c == cur_c && (px < 2 || px > 37 || ln < 2 || ln > 37))
        e.col = 3'b100;
      else if (d[4] && fc == 3'b001)
        e.col = 3'b010;
      else
        e.col = fc;
      e.dig = d[3:0];
      e.pos = {6'(ln), 6'(px)};
    end
    e.addr = 7'(last_addr);
    ring[cyc % 8] = e;
    if (prev_vs && !vs) begin
      nfalls++;
      cur_r = int'(cursor_row);
      cur_c = int'(cursor_col);
    end
    prev_vs = vs;
  endtask

  task automatic step(input int x, input int y, input bit de, input bit hs, input bit vs);
    @(negedge clk);
    check_val("color_out",  32'(color_out),  32'(ring[(cyc - 6) % 8].col));
    check_val("de_out",     32'(de_out),     32'(ring[(cyc - 6) % 8].de));
    check_val("hsync_out",  32'(hsync_out),  32'(ring[(cyc - 6) % 8].hs));
    check_val("vsync_out",  32'(vsync_out),  32'(ring[(cyc - 6) % 8].vs));
    check_val("board_addr", 32'(board_addr), 32'(ring[(cyc - 2) % 8].addr));
    check_val("font_digit", 32'(font_digit), 32'(ring[(cyc - 3) % 8].dig));
    check_val("font_pos",   32'(font_pos),   32'(ring[(cyc - 3) % 8].pos));
    pixel_x = 10'(x); pixel_y = 10'(y);
    de_in = de; hsync_in = hs; vsync_in = vs;
    model_push(x, y, de, hs, vs);
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, " color_out"},  32'(color_out),  32'd0);
    check_val({tag, " de_out"},     32'(de_out),     32'd0);
    check_val({tag, " hsync_out"},  32'(hsync_out),  32'd1);
    check_val({tag, " vsync_out"},  32'(vsync_out),  32'd1);
    check_val({tag, " board_addr"}, 32'(board_addr), 32'd0);
    check_val({tag, " font_digit"}, 32'(font_digit), 32'd0);
    check_val({tag, " font_pos"},   32'(font_pos),   32'd0);
  endtask

  // Reset asserted between clock edges; outputs must clear without an edge.
  task automatic reset_midline();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);
    rst_n = 1'b1;
  endtask

  task automatic quick_frame();
    step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1); step(0, 0, 0, 1, 1);
  endtask

  task automatic set_sweeps(input int n_random);
    for (int i = 0; i < 512; i++) sweep_y[i] = 1'b0;
    sweep_y[GY + 3] = 1'b1;   sweep_y[GY + 160] = 1'b1; sweep_y[GY + 161] = 1'b1;
    sweep_y[GY + 175] = 1'b1; sweep_y[GY + 199] = 1'b1;
    sweep_y[GY + 359] = 1'b1; sweep_y[GY + 360] = 1'b1;
    for (int i = 0; i < n_random; i++) sweep_y[GY + $urandom_range(0, 361)] = 1'b1;
  endtask

  // Compressed frame: vsync pulse, then every line crosses GRID_X once with
  // consecutive x; selected lines sweep the full grid width.
  task automatic run_frame();
    int xs, xe;
    bit sw, de;
    step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1); step(0, 0, 0, 1, 1);
    for (int y = GY - 1; y <= GY + 361; y++) begin
      if (y == chg_line) cursor_col = 4'(chg_col);
      sw = sweep_y[y];
      xs = sw ? GX - 3 : GX - 2;
      xe = sw ? GX + 363 : GX + 2;
      for (int x = xs; x <= xe; x++) begin
        if (y == rst_line && x == GX + 100) begin
          reset_midline();
          return;
        end
        de = sw ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 1) == 1);
        step(x, y, de, x != xs, 1);
      end
    end
  endtask

  task automatic fill_board();
    for (int i = 0; i < 81; i++) board[i] = 5'($urandom);
    board[1] = 5'b1_0101;
  endtask

  initial begin
    fill_board();
    model_reset();
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("init_rst");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1);

    // Frame 1: cursor (4,4), blink on.
    cursor_row = 4'd4; cursor_col = 4'd4;
    set_sweeps(5);
    run_frame();
    // Fall #30 turns the border off.
    for (int i = 0; i < BF - 2; i++) quick_frame();
    set_sweeps(2);
    run_frame();
    // Fall #60 turns it back on; a mid-frame cursor move must not take effect.
    for (int i = 0; i < BF - 1; i++) quick_frame();
    chg_line = GY + 100; chg_col = 5;
    run_frame();
    chg_line = -1;
    // Next frame latches the moved cursor.
    run_frame();
    // Out-of-range cursor row is never highlighted.
    cursor_row = 4'd9; cursor_col = 4'd4;
    run_frame();
    // Reset mid-line, then idle with de low.
    cursor_row = 4'd2; cursor_col = 4'd7;
    sweep_y[GY + 50] = 1'b1;
    rst_line = GY + 50;
    run_frame();
    rst_line = -1;
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 1);
    // Fresh board and frame after reset.
    fill_board();
    set_sweeps(4);
    run_frame();
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
